// File: rtl/hard_mem_1rw_mask_hold_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module  : hard_mem_1rw_mask_hold_wrapper_if
// Brief   : Request and held-response bundle for the 1RW masked memory wrapper.
// Revision: 1.0  initial release
// ============================================================================
interface hard_mem_1rw_mask_hold_wrapper_if #(
    parameter int width_p      = 64,
    parameter int addr_width_p = 9,
    parameter int mask_width_p = 8
);
    logic                    v_i;
    logic                    ready_o;
    logic                    w_i;
    logic [addr_width_p-1:0] addr_i;
    logic [width_p-1:0]      data_i;
    logic [mask_width_p-1:0] w_mask_i;
    logic                    data_v_o;
    logic [width_p-1:0]      data_o;
    logic                    yumi_i;

    // Requester / response consumer side
    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i, yumi_i,
        input  ready_o, data_v_o, data_o
    );

    // Wrapper side
    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i, yumi_i,
        output ready_o, data_v_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/hard_mem_1rw_mask_hold_wrapper.sv
`default_nettype none
// ============================================================================
// Module  : hard_mem_1rw_mask_hold_wrapper
// Brief   : Single-port masked SRAM wrapper with valid/ready requests and a
//           held, valid/yumi read response. Optional access counters are
//           enabled with HARD_MEM_WRAPPER_STATS_EN.
// Revision: 1.0  initial release
// ============================================================================
module hard_mem_1rw_mask_hold_wrapper #(
    parameter int  width_p       = 64,
    parameter int  els_p         = 512,
    parameter int  mask_gran_p   = 8,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp = width_p / mask_gran_p
) (
    input  wire logic                          clk_i,
    input  wire logic                          reset_i,
    hard_mem_1rw_mask_hold_wrapper_if.slave    bus
`ifdef HARD_MEM_WRAPPER_STATS_EN
    ,
    output logic [31:0]                        rd_count_o,
    output logic [31:0]                        wr_count_o
`endif
);

    localparam logic [addr_width_lp:0] c_els = (addr_width_lp + 1)'(els_p);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_data_v;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_in_range;
    logic [width_p-1:0]   w_bit_mask;
    logic [width_p-1:0]   r_data;
    logic [width_p-1:0]   r_mem [0:els_p-1];

    if (width_p % mask_gran_p != 0) begin : g_err_gran
        $error("width_p must be a multiple of mask_gran_p");
    end
    if (els_p < 2) begin : g_err_depth
        $error("els_p must be at least 2");
    end

    // A request is never taken while reset is asserted, so no write lands in reset.
    assign w_ready    = (r_state == S_EMPTY) | bus.yumi_i;
    assign w_accept   = bus.v_i & w_ready & reset_i;
    assign w_rd       = w_accept & ~bus.w_i;
    assign w_wr       = w_accept & bus.w_i;
    assign w_in_range = ({1'b0, bus.addr_i} < c_els);

    for (genvar k = 0; k < mask_width_lp; k++) begin : g_mask
        assign w_bit_mask[k*mask_gran_p +: mask_gran_p] = {mask_gran_p{bus.w_mask_i[k]}};
    end

    // Behavioural stand-in for the hardened macro; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (w_wr && w_in_range) begin
            r_mem[bus.addr_i] <= (r_mem[bus.addr_i] & ~w_bit_mask)
                               | (bus.data_i & w_bit_mask);
        end
    end

    // Hold register: the macro is read once per accepted read, then the word is kept here.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_data <= '0;
        end else if (w_rd) begin
            r_data <= w_in_range ? r_mem[bus.addr_i] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_data_v     = 1'b0;
        unique case (r_state)
            S_EMPTY: begin
                if (w_rd) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                w_data_v = 1'b1;
                if (bus.yumi_i && !w_rd) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    assign bus.ready_o  = w_ready;
    assign bus.data_v_o = w_data_v;
    assign bus.data_o   = r_data;

`ifdef HARD_MEM_WRAPPER_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    // Both counters saturate rather than wrap; out-of-range accesses count too.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd && (r_rd_count != 32'hFFFF_FFFF)) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count_o = r_rd_count;
    assign wr_count_o = r_wr_count;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert (!(bus.yumi_i && (r_state == S_EMPTY)))
                else $error("yumi_i asserted with no response held");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hard_mem_1rw_mask_hold_wrapper.sv
`default_nettype none
// ============================================================================
// Module  : tb_hard_mem_1rw_mask_hold_wrapper
// Brief   : Directed vector bench for the masked 1RW hold wrapper (three geometries).
// Revision: 1.0  initial release
// ============================================================================
module tb_hard_mem_1rw_mask_hold_wrapper;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    hard_mem_1rw_mask_hold_wrapper_if #(.width_p(64), .addr_width_p(9), .mask_width_p(8))  ifa ();
    hard_mem_1rw_mask_hold_wrapper_if #(.width_p(15), .addr_width_p(6), .mask_width_p(15)) ifb ();
    hard_mem_1rw_mask_hold_wrapper_if #(.width_p(64), .addr_width_p(9), .mask_width_p(8))  ifc ();

    hard_mem_1rw_mask_hold_wrapper #(.width_p(64), .els_p(512), .mask_gran_p(8)) dut_a (
        .clk_i(clk), .reset_i(rst_n), .bus(ifa)
    );
    hard_mem_1rw_mask_hold_wrapper #(.width_p(15), .els_p(64), .mask_gran_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst_n), .bus(ifb)
    );
    hard_mem_1rw_mask_hold_wrapper #(.width_p(64), .els_p(300), .mask_gran_p(8)) dut_c (
        .clk_i(clk), .reset_i(rst_n), .bus(ifc)
    );

    typedef struct {
        logic        v;
        logic        w;
        logic [8:0]  addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic        yumi;
        logic        exp_ready;
        logic        exp_v;
        logic        chk_d;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic w, input logic [8:0] a,
                           input logic [63:0] d, input logic [7:0] m, input logic y);
        ifa.v_i = v; ifa.w_i = w; ifa.addr_i = a; ifa.data_i = d; ifa.w_mask_i = m; ifa.yumi_i = y;
    endtask

    task automatic drive_b(input logic v, input logic w, input logic [5:0] a,
                           input logic [14:0] d, input logic [14:0] m, input logic y);
        ifb.v_i = v; ifb.w_i = w; ifb.addr_i = a; ifb.data_i = d; ifb.w_mask_i = m; ifb.yumi_i = y;
    endtask

    task automatic drive_c(input logic v, input logic w, input logic [8:0] a,
                           input logic [63:0] d, input logic [7:0] m, input logic y);
        ifc.v_i = v; ifc.w_i = w; ifc.addr_i = a; ifc.data_i = d; ifc.w_mask_i = m; ifc.yumi_i = y;
    endtask

    function automatic logic [63:0] stream_word(input int i);
        return 64'h5EED_0000_0000_0000 + 64'(i) * 64'h0001_0001_0001_0001;
    endfunction

    localparam logic [63:0] X5  = 64'h1122_3344_AAAA_AAAA;
    localparam logic [63:0] X5B = 64'h0022_3344_AAAA_AAAA;
    localparam logic [63:0] C6  = 64'hCAFE_F00D_DEAD_BEEF;
    localparam logic [63:0] D7  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] K9  = 64'h9999_8888_7777_6666;
    localparam logic [63:0] K2  = 64'h0BAD_CAFE_1234_5678;

    initial begin
        checks = 0;
        errors = 0;

        //            v  w  addr data                      mask   y   rdy v  chk exp_d
        tbl[0]  = '{1, 1, 9'd5, 64'h1122_3344_5566_7788, 8'hFF, 0,  1, 0, 1, 64'h0};
        tbl[1]  = '{1, 1, 9'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0,  1, 0, 1, 64'h0};
        tbl[2]  = '{1, 1, 9'd6, C6,                      8'hFF, 0,  1, 0, 1, 64'h0};
        tbl[3]  = '{1, 0, 9'd5, 64'h0,                   8'h00, 0,  1, 1, 1, X5};
        tbl[4]  = '{1, 0, 9'd6, 64'h0,                   8'h00, 0,  0, 1, 1, X5};
        tbl[5]  = '{1, 0, 9'd6, 64'h0,                   8'h00, 0,  0, 1, 1, X5};
        tbl[6]  = '{1, 0, 9'd6, 64'h0,                   8'h00, 0,  0, 1, 1, X5};
        tbl[7]  = '{1, 0, 9'd6, 64'h0,                   8'h00, 0,  0, 1, 1, X5};
        tbl[8]  = '{1, 0, 9'd6, 64'h0,                   8'h00, 1,  1, 1, 1, C6};
        tbl[9]  = '{0, 0, 9'd0, 64'h0,                   8'h00, 1,  1, 0, 0, 64'h0};
        tbl[10] = '{1, 1, 9'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0,  1, 0, 0, 64'h0};
        tbl[11] = '{1, 0, 9'd5, 64'h0,                   8'h00, 0,  1, 1, 1, X5};
        tbl[12] = '{1, 1, 9'd7, D7,                      8'hFF, 1,  1, 0, 1, X5};
        tbl[13] = '{1, 0, 9'd7, 64'h0,                   8'h00, 0,  1, 1, 1, D7};
        tbl[14] = '{0, 0, 9'd0, 64'h0,                   8'h00, 1,  1, 0, 0, 64'h0};
        tbl[15] = '{1, 1, 9'd5, 64'h0,                   8'h80, 0,  1, 0, 0, 64'h0};
        tbl[16] = '{1, 0, 9'd5, 64'h0,                   8'h00, 0,  1, 1, 1, X5B};
        tbl[17] = '{0, 0, 9'd0, 64'h0,                   8'h00, 1,  1, 0, 0, 64'h0};

        // Reset held for three cycles with a write request asserted
        rst_n = 1'b0;
        drive_a(1, 1, 9'd9, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 0);
        drive_b(0, 0, 6'd0, 15'h0, 15'h0, 0);
        drive_c(0, 0, 9'd0, 64'h0, 8'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_v", 64'(ifa.data_v_o), 64'h0);
        chk("reset data", ifa.data_o, 64'h0);
        @(negedge clk);
        drive_a(0, 0, 9'd0, 64'h0, 8'h0, 0);
        rst_n = 1'b1;
        #1;
        chk("ready after release", 64'(ifa.ready_o), 64'h1);
        tick();

        // Table-driven vectors on the default geometry
        for (int i = 0; i < 18; i++) begin
            drive_a(tbl[i].v, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].yumi);
            #1;
            chk($sformatf("vec%0d ready", i), 64'(ifa.ready_o), 64'(tbl[i].exp_ready));
            tick();
            chk($sformatf("vec%0d data_v", i), 64'(ifa.data_v_o), 64'(tbl[i].exp_v));
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d data", i), ifa.data_o, tbl[i].exp_d);
            end
        end

        // Streaming: 16 reads back to back with yumi every cycle
        for (int i = 0; i < 16; i++) begin
            drive_a(1, 1, 9'(i), stream_word(i), 8'hFF, 0);
            tick();
        end
        for (int i = 0; i <= 16; i++) begin
            drive_a(i < 16, 0, 9'(i % 16), 64'h0, 8'h0, i > 0);
            #1;
            chk($sformatf("stream%0d ready", i), 64'(ifa.ready_o), 64'h1);
            tick();
            if (i < 16) begin
                chk($sformatf("stream%0d data_v", i), 64'(ifa.data_v_o), 64'h1);
                chk($sformatf("stream%0d data", i), ifa.data_o, stream_word(i));
            end else begin
                chk("stream end data_v", 64'(ifa.data_v_o), 64'h0);
            end
        end

        // Async reset while FULL; write during reset must not land
        drive_a(1, 1, 9'd9, K9, 8'hFF, 0);
        tick();
        drive_a(1, 0, 9'd9, 64'h0, 8'h0, 0);
        tick();
        chk("pre-reset data", ifa.data_o, K9);
        drive_a(1, 1, 9'd9, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset data_v", 64'(ifa.data_v_o), 64'h0);
        chk("async reset data", ifa.data_o, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("in reset ready", 64'(ifa.ready_o), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1, 0, 9'd9, 64'h0, 8'h0, 0);
        tick();
        chk("post-reset read", ifa.data_o, K9);
        drive_a(0, 0, 9'd0, 64'h0, 8'h0, 1);
        tick();
        drive_a(0, 0, 9'd0, 64'h0, 8'h0, 0);

        // Bit-granular mask (15-bit words)
        drive_b(1, 1, 6'd3, 15'h7FFF, 15'h7FFF, 0);
        tick();
        drive_b(1, 1, 6'd3, 15'h0000, 15'h0101, 0);
        tick();
        drive_b(1, 0, 6'd3, 15'h0, 15'h0, 0);
        tick();
        chk("bitmask data_v", 64'(ifb.data_v_o), 64'h1);
        chk("bitmask data", 64'(ifb.data_o), 64'h7EFE);
        drive_b(0, 0, 6'd0, 15'h0, 15'h0, 1);
        tick();
        chk("bitmask drain", 64'(ifb.data_v_o), 64'h0);
        drive_b(0, 0, 6'd0, 15'h0, 15'h0, 0);

        // Non-power-of-two depth: out-of-range and last valid word
        drive_c(1, 1, 9'd310, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        tick();
        drive_c(1, 1, 9'd299, K2, 8'hFF, 0);
        tick();
        drive_c(1, 0, 9'd310, 64'h0, 8'h0, 0);
        tick();
        chk("oor data_v", 64'(ifc.data_v_o), 64'h1);
        chk("oor data", ifc.data_o, 64'h0);
        drive_c(1, 0, 9'd299, 64'h0, 8'h0, 1);
        tick();
        chk("last word data_v", 64'(ifc.data_v_o), 64'h1);
        chk("last word data", ifc.data_o, K2);
        drive_c(0, 0, 9'd0, 64'h0, 8'h0, 1);
        tick();
        chk("oor drain", 64'(ifc.data_v_o), 64'h0);
        drive_c(0, 0, 9'd0, 64'h0, 8'h0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hard_mem_1rw_mask_hold_wrapper.md
Name: hard_mem_1rw_mask_hold_wrapper

Overview:
Parametrised successor to the fixed-geometry single-port hard-memory wrappers. It covers width, depth and write-mask granularity (bit, byte or any divisor of width) with one RTL model. It adds a valid/ready request interface and a registered, held read response with valid/yumi consumer handshake. It sits between cache/TLB control logic and the hardened SRAM macro, which is instanced as "mem" when hardened.

Parameters:
width_p, 64, data word width in bits; must be a multiple of mask_gran_p.
els_p, 512, number of words; need not be a power of two.
mask_gran_p, 8, bits per write-mask bit; 1 = bit mask, width_p = unmasked.
addr_width_lp, $clog2(els_p), address width (derived).
mask_width_lp, width_p/mask_gran_p, write-mask width (derived).

Ports:
clk_i  in  1  clock; all state on rising edge.
reset_i  in  1  asynchronous, active-low reset (0 = in reset).
v_i  in  1  request valid.
ready_o  out  1  wrapper can accept a request this cycle.
w_i  in  1  1 = write, 0 = read; qualified by v_i.
addr_i  in  addr_width_lp  word address.
data_i  in  width_p  write data.
w_mask_i  in  mask_width_lp  write mask; bit k enables data bits [k*mask_gran_p +: mask_gran_p].
data_v_o  out  1  read response valid.
data_o  out  width_p  read response data.
yumi_i  in  1  consumer takes the response; legal only when data_v_o=1.

Behaviour:
- Reset (reset_i=0, async assert, sync deassert by the integrator): data_v_o=0, data_o=0, ready_o=1 after release. Memory contents are not reset. A pending response is dropped.
- Handshake: a request is accepted on v_i & ready_o. ready_o = ~data_v_o | yumi_i, which is combinational from yumi_i. Back-to-back reads at one per cycle are supported while the consumer yumis every cycle.
- Two-state FSM:
  - EMPTY: data_v_o=0.
  - FULL: data_v_o=1.
  - EMPTY -> FULL on an accepted read.
  - FULL -> EMPTY on yumi_i without an accepted read.
  - FULL -> FULL on yumi_i with an accepted read; data_o is replaced next cycle.
- Read latency is exactly 1 cycle: data_o = mem[addr_i] at the cycle after acceptance. data_o and data_v_o then hold stable until the cycle after yumi_i. The SRAM is not re-read while holding; a hold register captures the word.
- Write: on acceptance with w_i=1, every granule with w_mask_i[k]=1 is updated at the clock edge. Granules with mask bit 0 are unchanged. A write produces no response and does not change data_o or data_v_o.
- Write and read in the same cycle are impossible (single port). A read of an address written in the previous cycle returns the new data.
- All-zero w_mask_i: the write is accepted and memory is unchanged.
- addr_i >= els_p (non-power-of-two depth):
  - write: accepted and discarded;
  - read: accepted, response data is all zeros, data_v_o asserts normally.
- Reading a never-written word returns X in simulation; no initialisation is done.
- yumi_i=1 while data_v_o=0 is illegal. A simulation-only assertion fires; the RTL ignores it.
- v_i while ready_o=0: the request is not accepted and the producer must hold it. Inputs are not sampled.
- Elaboration checks: width_p % mask_gran_p == 0 and els_p >= 2, else $error.

Optional Feature:
HARD_MEM_WRAPPER_STATS_EN
- Defined: adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - They count accepted reads and writes respectively and saturate at 32'hFFFF_FFFF.
  - Both reset to 0 on reset_i=0.
  - Out-of-range accesses are counted.
- Undefined: the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
Defaults used throughout (width_p 64, els_p 512, mask_gran_p 8).
- Reset: hold reset_i=0 for 3 cycles with v_i=1 -> data_v_o=0, data_o=0, no write takes effect. After release, ready_o=1.
- Masked write then read: write addr 5, data 64'h1122_3344_5566_7788, mask 8'hFF. Then write data 64'hAAAA_AAAA_AAAA_AAAA with mask 8'h0F. Read addr 5 -> one cycle later data_v_o=1, data_o=64'h1122_3344_AAAA_AAAA.
- Hold/backpressure: read addr 5 with yumi_i=0 for 4 cycles, v_i held with a read of addr 6 -> ready_o=0 and data_o stable for all 4 cycles. Assert yumi_i -> addr-6 data appears the next cycle.
- Streaming: reads of addrs 0..15 with yumi_i=1 every cycle -> 16 responses on 16 consecutive cycles, in order, with ready_o constant 1.
- Bit granularity (mask_gran_p=1, width_p=15, els_p=64): write 15'h7FFF, then write 15'h0000 with mask 15'h0101 -> read returns 15'h7EFE.
- Out of range (els_p=300): write addr 310 then read addr 310 -> data_o=0 and data_v_o=1. Async reset while FULL -> data_v_o drops to 0 immediately, with no clock edge required.
